// File: rtl/bootram_bus_bridge.sv
// rtl/bootram_bus_bridge.sv - PicoRV32 native-bus responder for four 2Kx8 boot-RAM byte lanes.
// Optional byte-stream loader enabled by defining BOOTRAM_LOADER_EN.
module bootram_bus_bridge #(
    parameter int AW = 11
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          mem_valid,
    input  logic [31:0]   mem_addr,
    input  logic [31:0]   mem_wdata,
    input  logic [3:0]    mem_wstrb,
    output logic          mem_ready,
    output logic [31:0]   mem_rdata,
    output logic [3:0]    ram_ce,
    output logic [3:0]    ram_wre,
    output logic          ram_oce,
    output logic [AW-1:0] ram_ad,
    output logic [31:0]   ram_din,
    input  logic [31:0]   ram_dout,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic [7:0]    ld_data,
    input  logic          ld_start,
    output logic [AW+1:0] ld_count
);

    typedef enum logic [1:0] {IDLE, RD, ACK} state_t;

    state_t        state;
    state_t        state_nx;
    logic          ld_beat;
    logic [AW+1:0] ld_cnt;
    logic [3:0]    ld_lane;

    assign ram_oce = 1'b1;

`ifdef BOOTRAM_LOADER_EN
    // A start pulse blocks the beat so the counter restart is never lost.
    assign ld_ready = (state == IDLE) & ~ld_start;
    assign ld_beat  = ld_valid & ld_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ld_cnt <= '0;
        end else if (ld_start) begin
            ld_cnt <= '0;
        end else if (ld_beat) begin
            ld_cnt <= ld_cnt + 1'b1;
        end
    end
`else
    logic unused_loader;

    assign ld_ready      = 1'b0;
    assign ld_beat       = 1'b0;
    assign ld_cnt        = '0;
    assign unused_loader = &{1'b0, ld_valid, ld_start};
`endif

    assign ld_count = ld_cnt;
    assign ld_lane  = 4'b0001 << ld_cnt[1:0];

    logic unused_addr;
    assign unused_addr = &{1'b0, mem_addr[31:AW+2], mem_addr[1:0]};

    always_comb begin
        state_nx = state;
        ram_ce   = '0;
        ram_wre  = '0;
        ram_ad   = '0;
        ram_din  = '0;
        case (state)
            IDLE: begin
                // Loader has priority; the CPU request simply waits in IDLE.
                if (ld_beat) begin
                    ram_ce  = ld_lane;
                    ram_wre = ld_lane;
                    ram_ad  = ld_cnt[AW+1:2];
                    ram_din = {4{ld_data}};
                end else if (mem_valid) begin
                    ram_ad = mem_addr[AW+1:2];
                    if (|mem_wstrb) begin
                        ram_ce   = mem_wstrb;
                        ram_wre  = mem_wstrb;
                        ram_din  = mem_wdata;
                        state_nx = ACK;
                    end else begin
                        ram_ce   = 4'hF;
                        state_nx = RD;
                    end
                end
            end
            RD:      state_nx = ACK;
            ACK:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            mem_ready <= 1'b0;
            mem_rdata <= '0;
        end else begin
            state     <= state_nx;
            mem_ready <= (state_nx == ACK);
            if (state == RD) begin
                mem_rdata <= ram_dout;
            end
        end
    end

endmodule

// File: tb/tb_bootram_bus_bridge.sv
// tb/tb_bootram_bus_bridge.sv - scoreboard bench for bootram_bus_bridge with a behavioural 4-lane RAM.
module tb_bootram_bus_bridge;

    localparam int AW = 11;

    logic          clk;
    logic          resetn;
    logic          mem_valid;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_wstrb;
    logic          mem_ready;
    logic [31:0]   mem_rdata;
    logic [3:0]    ram_ce;
    logic [3:0]    ram_wre;
    logic          ram_oce;
    logic [AW-1:0] ram_ad;
    logic [31:0]   ram_din;
    logic [31:0]   ram_dout;
    logic          ld_valid;
    logic          ld_ready;
    logic [7:0]    ld_data;
    logic          ld_start;
    logic [AW+1:0] ld_count;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] exp_q[$];
    logic [31:0] shadow[2**AW];
    logic [31:0] last_read;
    logic [7:0]  lane_mem[4][2**AW];

    bootram_bus_bridge #(.AW(AW)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .ram_ce    (ram_ce),
        .ram_wre   (ram_wre),
        .ram_oce   (ram_oce),
        .ram_ad    (ram_ad),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_data   (ld_data),
        .ld_start  (ld_start),
        .ld_count  (ld_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte-lane RAMs: output register loads on a read-enabled cycle.
    always @(posedge clk) begin
        for (int n = 0; n < 4; n++) begin
            if (ram_ce[n]) begin
                if (ram_wre[n]) lane_mem[n][ram_ad] <= ram_din[8*n +: 8];
                else            ram_dout[8*n +: 8] <= lane_mem[n][ram_ad];
            end
        end
    end

    task automatic cpu_access(input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] wstrb, input int exp_lat,
                              input logic with_ld, input logic [7:0] ld_byte);
        int          idx;
        int          cyc;
        logic [31:0] exp;
        logic [31:0] got;
        idx = int'(addr[AW+1:2]);
        if (wstrb == 4'h0) begin
            last_read = shadow[idx];
        end else begin
            for (int b = 0; b < 4; b++)
                if (wstrb[b]) shadow[idx][8*b +: 8] = wdata[8*b +: 8];
        end
        exp_q.push_back(last_read);
        @(negedge clk);
        mem_valid = 1'b1;
        mem_addr  = addr;
        mem_wdata = wdata;
        mem_wstrb = wstrb;
        if (with_ld) begin
            ld_valid = 1'b1;
            ld_data  = ld_byte;
        end
        cyc = 0;
        while (cyc < 10) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            ld_valid = 1'b0;
            if (mem_ready) break;
        end
        mem_valid = 1'b0;
        mem_wstrb = 4'h0;
        n_cmp++;
        if (!mem_ready) begin
            n_err++;
            $display("FAIL access_timeout addr=%h: no mem_ready within %0d cycles", addr, cyc);
            void'(exp_q.pop_front());
        end else begin
            got = mem_rdata;
            exp = exp_q.pop_front();
            if (cyc != exp_lat) begin
                n_err++;
                $display("FAIL access_latency addr=%h: got %0d cycles, want %0d", addr, cyc, exp_lat);
            end
            n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL access_rdata addr=%h: got %h, want %h", addr, got, exp);
            end
            @(negedge clk);
            n_cmp++;
            if (mem_ready !== 1'b0) begin
                n_err++;
                $display("FAIL ready_width addr=%h: mem_ready got %b, want 0", addr, mem_ready);
            end
        end
    endtask

    task automatic test_reset();
        resetn    = 1'b0;
        mem_valid = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        ld_valid  = 1'b0;
        ld_data   = '0;
        ld_start  = 1'b0;
        last_read = '0;
        repeat (2) @(negedge clk);
        n_cmp += 6;
        if (mem_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready got %b want 0", mem_ready); end
        if (mem_rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata got %h want 0", mem_rdata); end
        if (ram_ce !== 4'h0) begin n_err++; $display("FAIL reset_ce got %h want 0", ram_ce); end
        if (ram_wre !== 4'h0) begin n_err++; $display("FAIL reset_wre got %h want 0", ram_wre); end
        if (ld_count !== 13'h0) begin n_err++; $display("FAIL reset_ld_count got %h want 0", ld_count); end
        if (ram_oce !== 1'b1) begin n_err++; $display("FAIL reset_oce got %b want 1", ram_oce); end
        resetn = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (ram_ad !== 11'h0) begin n_err++; $display("FAIL idle_ad got %h want 0", ram_ad); end
    endtask

    task automatic test_write_full();
        fork
            cpu_access(32'h10, 32'hA1B2C3D4, 4'hF, 1, 1'b0, 8'h00);
            begin
                @(negedge clk);
                #1;
                n_cmp += 3;
                if (ram_ad !== 11'h4) begin n_err++; $display("FAIL wr_ad got %h want 004", ram_ad); end
                if (ram_wre !== 4'hF) begin n_err++; $display("FAIL wr_wre got %h want f", ram_wre); end
                if (ram_din !== 32'hA1B2C3D4) begin n_err++; $display("FAIL wr_din got %h want a1b2c3d4", ram_din); end
            end
        join
    endtask

    task automatic test_byte_write_read();
        cpu_access(32'h10, 32'h000000EE, 4'b0001, 1, 1'b0, 8'h00);
        cpu_access(32'h10, 32'h0, 4'h0, 2, 1'b0, 8'h00);
        n_cmp++;
        if (last_read !== 32'hA1B2C3EE) begin
            n_err++;
            $display("FAIL model_byte_merge got %h want a1b2c3ee", last_read);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        for (int w = 8; w < 16; w++) cpu_access(32'(w * 4), $urandom, 4'hF, 1, 1'b0, 8'h00);
        for (int i = 0; i < 12; i++) begin
            a = $urandom;
            a[AW+1:2] = 11'($urandom_range(8, 15));
            if (i % 3 == 0) cpu_access(a, 32'h0, 4'h0, 2, 1'b0, 8'h00);
            else cpu_access(a, $urandom, 4'($urandom_range(1, 15)), 1, 1'b0, 8'h00);
        end
        a = 32'h8000_2010;
        cpu_access(a, 32'h0, 4'h0, 2, 1'b0, 8'h00);
    endtask

`ifdef BOOTRAM_LOADER_EN
    task automatic test_loader();
        logic [7:0] bytes_in[4];
        bytes_in = '{8'h11, 8'h22, 8'h33, 8'h44};
        @(negedge clk);
        ld_start = 1'b1;
        ld_valid = 1'b1;
        ld_data  = 8'hFF;
        #1;
        n_cmp++;
        if (ld_ready !== 1'b0) begin n_err++; $display("FAIL ld_start_ready got %b want 0", ld_ready); end
        @(negedge clk);
        ld_start = 1'b0;
        n_cmp++;
        if (ld_count !== 13'h0) begin n_err++; $display("FAIL ld_start_count got %h want 0", ld_count); end
        for (int i = 0; i < 4; i++) begin
            ld_data = bytes_in[i];
            shadow[0][8*i +: 8] = bytes_in[i];
            @(negedge clk);
        end
        ld_valid = 1'b0;
        n_cmp++;
        if (ld_count !== 13'h4) begin n_err++; $display("FAIL ld_count4 got %h want 4", ld_count); end
        cpu_access(32'h0, 32'h0, 4'h0, 2, 1'b0, 8'h00);
        n_cmp++;
        if (last_read !== 32'h44332211) begin n_err++; $display("FAIL model_ld_word got %h want 44332211", last_read); end
    endtask

    task automatic test_loader_vs_cpu();
        cpu_access(32'h4, 32'h0, 4'hF, 1, 1'b0, 8'h00);
        shadow[1][7:0] = 8'h5A;
        fork
            cpu_access(32'h4, 32'h0, 4'h0, 3, 1'b1, 8'h5A);
            begin
                @(negedge clk);
                #1;
                n_cmp += 2;
                if (ram_wre !== 4'b0001) begin n_err++; $display("FAIL ldcpu_wre got %h want 1", ram_wre); end
                if (ram_ad !== 11'h1) begin n_err++; $display("FAIL ldcpu_ad got %h want 001", ram_ad); end
            end
        join
        n_cmp++;
        if (ld_count !== 13'h5) begin n_err++; $display("FAIL ldcpu_count got %h want 5", ld_count); end
    endtask

    task automatic test_loader_wrap();
        @(negedge clk);
        ld_start = 1'b1;
        @(negedge clk);
        ld_start = 1'b0;
        ld_valid = 1'b1;
        for (int i = 0; i < 8191; i++) begin
            ld_data = 8'(i);
            shadow[i / 4][8*(i % 4) +: 8] = 8'(i);
            @(negedge clk);
        end
        n_cmp++;
        if (ld_count !== 13'h1FFF) begin n_err++; $display("FAIL wrap_pre_count got %h want 1fff", ld_count); end
        ld_data = 8'h9C;
        shadow[2047][31:24] = 8'h9C;
        #1;
        n_cmp += 2;
        if (ram_wre !== 4'b1000) begin n_err++; $display("FAIL wrap_wre got %h want 8", ram_wre); end
        if (ram_ad !== 11'h7FF) begin n_err++; $display("FAIL wrap_ad got %h want 7ff", ram_ad); end
        @(negedge clk);
        ld_valid = 1'b0;
        n_cmp++;
        if (ld_count !== 13'h0) begin n_err++; $display("FAIL wrap_count got %h want 0", ld_count); end
        cpu_access(32'h1FFC, 32'h0, 4'h0, 2, 1'b0, 8'h00);
        n_cmp++;
        if (last_read !== 32'h9CFEFDFC) begin n_err++; $display("FAIL model_wrap_word got %h want 9cfefdfc", last_read); end
        cpu_access(32'h0, 32'h0, 4'h0, 2, 1'b0, 8'h00);
    endtask
`else
    task automatic test_loader_disabled();
        @(negedge clk);
        ld_valid = 1'b1;
        ld_data  = 8'h77;
        #1;
        n_cmp += 2;
        if (ld_ready !== 1'b0) begin n_err++; $display("FAIL nold_ready got %b want 0", ld_ready); end
        if (ram_ce !== 4'h0) begin n_err++; $display("FAIL nold_ce got %h want 0", ram_ce); end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (ld_count !== 13'h0) begin n_err++; $display("FAIL nold_count got %h want 0", ld_count); end
        cpu_access(32'h10, 32'h0, 4'h0, 2, 1'b0, 8'h00);
        ld_valid = 1'b0;
    endtask
`endif

    task automatic test_reset_mid_read();
        cpu_access(32'h24, 32'h5566_7788, 4'hF, 1, 1'b0, 8'h00);
        @(negedge clk);
        mem_valid = 1'b1;
        mem_addr  = 32'h24;
        mem_wstrb = 4'h0;
        @(negedge clk);
        resetn    = 1'b0;
        mem_valid = 1'b0;
        #1;
        n_cmp += 2;
        if (mem_ready !== 1'b0) begin n_err++; $display("FAIL midrst_ready got %b want 0", mem_ready); end
        if (mem_rdata !== 32'h0) begin n_err++; $display("FAIL midrst_rdata got %h want 0", mem_rdata); end
        repeat (2) begin
            @(negedge clk);
            n_cmp++;
            if (mem_ready !== 1'b0) begin n_err++; $display("FAIL midrst_hold got %b want 0", mem_ready); end
        end
        resetn    = 1'b1;
        last_read = 32'h0;
        cpu_access(32'h28, 32'h0BAD_F00D, 4'hF, 1, 1'b0, 8'h00);
        cpu_access(32'h24, 32'h0, 4'h0, 2, 1'b0, 8'h00);
    endtask

    initial begin
        test_reset();
        test_write_full();
        test_byte_write_read();
        test_back_to_back();
`ifdef BOOTRAM_LOADER_EN
        test_loader();
        test_loader_vs_cpu();
        test_loader_wrap();
`else
        test_loader_disabled();
`endif
        test_reset_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
